// File: rtl/ex_mem_stage.sv
// ----------------------------------------------------------------------------
// ex_mem_stage
//   Execute stage of the 64-bit RISC-V five-stage pipeline together with the
//   EX/MEM pipeline register. Operands are forwarded from this block's own
//   registered result (EX/MEM) or from the MEM/WB write-back bus. The block
//   then computes the ALU result and the branch decision, and registers
//   everything at the EX/MEM boundary. The registered branch decision is also
//   the flush for IF/ID, ID/EX and for this block's own next capture.
//
// Ports
//   clk, reset (async, active-low), stall (hold EX/MEM register)
//   pc_in, rs1_data, rs2_data, imm, function_code, rd, rs1, rs2 : ID/EX data
//   MemtoReg, RegWrite, Branch, MemWrite, MemRead, ALUSrc, ALU_op : ID/EX ctrl
//   wb_data, wb_rd, wb_RegWrite : MEM/WB write-back bus for forwarding
//   alu_result_out, write_data_out, rd_out, *_out controls : EX/MEM register
//   branch_taken_out, branch_target_out : registered redirect / flush
// ----------------------------------------------------------------------------
module ex_mem_stage #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic [XLEN-1:0] pc_in,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [XLEN-1:0] imm,
   input  logic [3:0]      function_code,
   input  logic [4:0]      rd,
   input  logic [4:0]      rs1,
   input  logic [4:0]      rs2,
   input  logic            MemtoReg,
   input  logic            RegWrite,
   input  logic            Branch,
   input  logic            MemWrite,
   input  logic            MemRead,
   input  logic            ALUSrc,
   input  logic [1:0]      ALU_op,
   input  logic [XLEN-1:0] wb_data,
   input  logic [4:0]      wb_rd,
   input  logic            wb_RegWrite,
   output logic [XLEN-1:0] alu_result_out,
   output logic [XLEN-1:0] write_data_out,
   output logic [4:0]      rd_out,
   output logic            MemtoReg_out,
   output logic            RegWrite_out,
   output logic            MemWrite_out,
   output logic            MemRead_out,
   output logic            branch_taken_out,
   output logic [XLEN-1:0] branch_target_out
);

   // ALU: ALU_op selects a fixed add/sub or decodes {instr[30], funct3}.
   // For I-type arithmetic instr[30] is immediate bits, so it only matters
   // for the srai/srli pair.
   function automatic logic [XLEN-1:0] alu_calc(input logic [1:0]      op,
                                                input logic [3:0]      fc,
                                                input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
      logic [3:0]      code;
      logic [5:0]      shamt;
      logic [XLEN-1:0] res;
      shamt = b[5:0];
      case (op)
         2'b00:   code = 4'b0000;
         2'b01:   code = 4'b1000;
         2'b10:   code = fc;
         2'b11:   code = (fc[2:0] == 3'b101) ? fc : {1'b0, fc[2:0]};
         default: code = 4'b0000;
      endcase
      case (code)
         4'b0000: res = a + b;
         4'b1000: res = a - b;
         4'b0001: res = a << shamt;
         4'b0010: res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
         4'b0011: res = {{(XLEN-1){1'b0}}, (a < b)};
         4'b0100: res = a ^ b;
         4'b0101: res = a >> shamt;
         4'b1101: res = $signed(a) >>> shamt;
         4'b0110: res = a | b;
         4'b0111: res = a & b;
         default: res = a + b;
      endcase
      return res;
   endfunction

   // Branch condition on the forwarded operands; undefined funct3 is not taken.
   function automatic logic branch_cond(input logic [2:0]      f3,
                                        input logic [XLEN-1:0] a,
                                        input logic [XLEN-1:0] b);
      logic c;
      case (f3)
         3'b000:  c = (a == b);
         3'b001:  c = (a != b);
         3'b100:  c = ($signed(a) <  $signed(b));
         3'b101:  c = ($signed(a) >= $signed(b));
         3'b110:  c = (a <  b);
         3'b111:  c = (a >= b);
         default: c = 1'b0;
      endcase
      return c;
   endfunction

   logic [XLEN-1:0] alu_result_q, alu_result_d;
   logic [XLEN-1:0] write_data_q, write_data_d;
   logic [XLEN-1:0] branch_target_q, branch_target_d;
   logic [4:0]      rd_q, rd_d;
   logic            mem_to_reg_q, mem_to_reg_d;
   logic            reg_write_q, reg_write_d;
   logic            mem_write_q, mem_write_d;
   logic            mem_read_q, mem_read_d;
   logic            branch_taken_q, branch_taken_d;

   logic [XLEN-1:0] fwd_a_s, fwd_b_s, op2_s;

   // Operand forwarding: EX/MEM result beats MEM/WB, x0 is never forwarded.
   always_comb begin
      fwd_a_s = rs1_data;
      fwd_b_s = rs2_data;
      if ((rs1 != 5'd0) && reg_write_q && (rd_q == rs1)) begin
         fwd_a_s = alu_result_q;
      end else if ((rs1 != 5'd0) && wb_RegWrite && (wb_rd == rs1)) begin
         fwd_a_s = wb_data;
      end else begin
         fwd_a_s = rs1_data;
      end
      if ((rs2 != 5'd0) && reg_write_q && (rd_q == rs2)) begin
         fwd_b_s = alu_result_q;
      end else if ((rs2 != 5'd0) && wb_RegWrite && (wb_rd == rs2)) begin
         fwd_b_s = wb_data;
      end else begin
         fwd_b_s = rs2_data;
      end
   end

   assign op2_s = ALUSrc ? imm : fwd_b_s;

   // EX/MEM next state: stall holds, a pending redirect squashes the
   // wrong-path instruction into a bubble, otherwise capture EX results.
   always_comb begin
      alu_result_d    = alu_result_q;
      write_data_d    = write_data_q;
      branch_target_d = branch_target_q;
      rd_d            = rd_q;
      mem_to_reg_d    = mem_to_reg_q;
      reg_write_d     = reg_write_q;
      mem_write_d     = mem_write_q;
      mem_read_d      = mem_read_q;
      branch_taken_d  = branch_taken_q;
      if (stall) begin
         branch_taken_d = branch_taken_q;
      end else if (branch_taken_q) begin
         alu_result_d    = {XLEN{1'b0}};
         write_data_d    = {XLEN{1'b0}};
         branch_target_d = {XLEN{1'b0}};
         rd_d            = 5'd0;
         mem_to_reg_d    = 1'b0;
         reg_write_d     = 1'b0;
         mem_write_d     = 1'b0;
         mem_read_d      = 1'b0;
         branch_taken_d  = 1'b0;
      end else begin
         alu_result_d    = alu_calc(ALU_op, function_code, fwd_a_s, op2_s);
         write_data_d    = fwd_b_s;
         branch_target_d = pc_in + {imm[XLEN-2:0], 1'b0};
         rd_d            = rd;
         mem_to_reg_d    = MemtoReg;
         reg_write_d     = RegWrite;
         mem_write_d     = MemWrite;
         mem_read_d      = MemRead;
         branch_taken_d  = Branch & branch_cond(function_code[2:0], fwd_a_s, fwd_b_s);
      end
   end

   // EX/MEM pipeline register with asynchronous active-low clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         alu_result_q    <= {XLEN{1'b0}};
         write_data_q    <= {XLEN{1'b0}};
         branch_target_q <= {XLEN{1'b0}};
         rd_q            <= 5'd0;
         mem_to_reg_q    <= 1'b0;
         reg_write_q     <= 1'b0;
         mem_write_q     <= 1'b0;
         mem_read_q      <= 1'b0;
         branch_taken_q  <= 1'b0;
      end else begin
         alu_result_q    <= alu_result_d;
         write_data_q    <= write_data_d;
         branch_target_q <= branch_target_d;
         rd_q            <= rd_d;
         mem_to_reg_q    <= mem_to_reg_d;
         reg_write_q     <= reg_write_d;
         mem_write_q     <= mem_write_d;
         mem_read_q      <= mem_read_d;
         branch_taken_q  <= branch_taken_d;
      end
   end

   assign alu_result_out    = alu_result_q;
   assign write_data_out    = write_data_q;
   assign branch_target_out = branch_target_q;
   assign rd_out            = rd_q;
   assign MemtoReg_out      = mem_to_reg_q;
   assign RegWrite_out      = reg_write_q;
   assign MemWrite_out      = mem_write_q;
   assign MemRead_out       = mem_read_q;
   assign branch_taken_out  = branch_taken_q;

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Execute stage plus EX/MEM pipeline register for the 64-bit RISC-V five-stage pipeline. It consumes the ID/EX register outputs. It resolves operand forwarding, performs the ALU operation and evaluates branch conditions. It registers results, memory controls and the branch redirect into the EX/MEM boundary. Its registered branch decision drives the pipeline flush for IF/ID, ID/EX and its own next capture.

## Interface
- XLEN, 64, datapath width; all data/address ports are XLEN bits.
- clk  in  1  clock; all registers update on posedge.
- reset  in  1  asynchronous, active-low reset; one clock domain.
- stall  in  1  hold EX/MEM register (downstream memory wait).
- pc_in  in  XLEN  instruction PC from ID/EX.
- rs1_data, rs2_data  in  XLEN  register-file operands from ID/EX.
- imm  in  XLEN  sign-extended immediate from ID/EX (halfword-scaled for branches).
- function_code  in  4  {instr[30], funct3}.
- rd, rs1, rs2  in  5  register indices.
- MemtoReg, RegWrite, Branch, MemWrite, MemRead, ALUSrc  in  1  controls from ID/EX.
- ALU_op  in  2  00 add, 01 branch compare, 10 R-type, 11 I-type arithmetic.
- wb_data  in  XLEN  MEM/WB write-back value; wb_rd in 5; wb_RegWrite in 1.
- alu_result_out  out  XLEN  registered ALU result.
- write_data_out  out  XLEN  registered forwarded rs2 value (store data).
- rd_out  out  5; MemtoReg_out, RegWrite_out, MemWrite_out, MemRead_out  out  1.
- branch_taken_out  out  1  registered redirect; also the Flush for IF/ID and ID/EX.
- branch_target_out  out  XLEN  registered redirect address.

## Operation
- Forwarding, per operand A (rs1) and B (rs2), evaluated independently:
  - Index 0 is never forwarded.
  - First choice is this block's own registers: RegWrite_out=1 and rd_out==index selects alu_result_out.
  - Otherwise wb_RegWrite=1 and wb_rd==index selects wb_data.
  - Otherwise the ID/EX data is used.
  - Load-use hazards are removed upstream; no load-data forwarding here.
- ALU second operand: imm if ALUSrc=1, else forwarded B. write_data always takes forwarded B.
- ALU_op 00: add. ALU_op 01: sub; the branch condition is computed in parallel.
- ALU_op 10, function_code: 0000 add, 1000 sub, 0001 sll, 0010 slt, 0011 sltu, 0100 xor, 0101 srl, 1101 sra, 0110 or, 0111 and. Other codes give add.
- ALU_op 11: as ALU_op 10, but bit 3 is ignored except when funct3=101 (srai vs srli).
- Arithmetic wraps mod 2^64. Shift amount is operand2[5:0]. slt is signed 64-bit; sltu is unsigned. Results are 0/1 zero-extended.
- Branch condition on the forwarded operands, by funct3:
  - 000 eq, 001 ne, 100 lt signed, 101 ge signed, 110 ltu, 111 geu.
  - Undefined funct3 gives not-taken.
- taken = Branch & condition. target = pc_in + (imm << 1), mod 2^64.

## Timing
- Reset (asynchronous, active-low): every output register is 0. No pending redirect after reset release.
- Latency: EX inputs are visible at the outputs after one posedge. The redirect is visible the cycle after the branch is in EX.
- Edge behaviour, highest priority first:
  1. reset asserted: all registers cleared.
  2. stall=1: every register holds, including branch_taken_out and branch_target_out.
  3. branch_taken_out=1 and stall=0: the instruction currently in EX is wrong-path. Capture a bubble: all controls 0, rd_out=0, data 0, branch_taken_out=0. branch_taken_out is therefore a one-cycle pulse per taken branch when not stalled.
  4. Otherwise: capture the computed values. Control outputs are copied unchanged; Branch is consumed here and not propagated.
- Forwarding uses register values from before the edge, so back-to-back dependents see the previous result with no bubble.
- Reset asserted mid-stall or mid-redirect discards the pending redirect.

## Test plan
- Reset: assert reset=0 mid-operation -> all outputs 0 immediately; branch_taken_out=0 after release.
- R-type chain: add x5=3+4, then sub x6=x5-1 back-to-back -> alu_result_out 7 then 6, via EX/MEM forward. With x5 also pending in MEM/WB as 99, the EX/MEM value 7 wins.
- Arithmetic edges:
  - sra of 0x8000_0000_0000_0000 by 63 -> 0xFFFF_FFFF_FFFF_FFFF.
  - srl of the same value by 63 -> 1.
  - slt -1 vs 1 -> 1; sltu -1 vs 1 -> 0.
  - add 0xFFFF_FFFF_FFFF_FFFF + 1 -> 0.
- Taken beq: pc_in=0x100, imm=8, equal operands -> next cycle branch_taken_out=1 and target 0x110. The following instruction is captured as a bubble (RegWrite_out=0, MemWrite_out=0). bne with equal operands -> no redirect.
- Stall during redirect: stall=1 for 3 cycles while branch_taken_out=1 -> outputs held for 3 cycles. The first unstalled edge captures a bubble and branch_taken_out drops.
- x0 guard: RegWrite_out=1 with rd_out=0 and alu_result_out=5; next instruction reads rs1=x0 -> operand is the ID/EX value 0, not 5.
